hazard_stall_ctrl: RTL

//   Pipeline hazard/stall controller for the 5-stage MIPS core. Decides each cycle whether
//   PC, IF/ID, ID/EX and EX/MEM advance, hold, bubble or flush. Handles load-use hazards,

---
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of hazard/stall controller signals between the pipeline datapath and the controller.
// The master side is the pipeline and the slave side is the controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             ex_branch_tk;
  logic             ex_mdu_start;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_bubble;
  logic             exmem_hold;
  logic             exmem_bubble;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       dbg_state;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_tk, ex_mdu_start, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
           exmem_hold, exmem_bubble, mdu_busy, stall_cycles, flush_count, dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_tk, ex_mdu_start, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
           exmem_hold, exmem_bubble, mdu_busy, stall_cycles, flush_count, dbg_state
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, multi-cycle MDU stalls
// and data-memory freezes, plus saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic               clock,
  input logic               reset,
  hazard_stall_ctrl_if.slave hz
);
  localparam int CW = $clog2(MDU_LAT) + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic load_use, mdu_phase, cnt_dec_to_zero, mdu_start_ok;
  logic [CW-1:0] cnt_dec;
  logic pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble;
  logic exmem_hold, exmem_bubble, mdu_busy;

  assign load_use = hz.idex_mem_read && (hz.idex_rt != 5'd0) &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.idex_rt)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.idex_rt)));

  // A memory wait that interrupted an MDU op resumes the MDU stall until the count expires.
  assign mdu_phase       = (state_q == MDU_WAIT) || ((state_q == MEM_WAIT) && (mdu_cnt_q != '0));
  assign cnt_dec         = (mdu_cnt_q != '0) ? mdu_cnt_q - CW'(1) : '0;
  assign cnt_dec_to_zero = (mdu_cnt_q == CW'(1));
  assign mdu_start_ok    = hz.ex_mdu_start && !done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
      done_q    <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      done_q    <= done_d;
      if (!pc_write && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    done_d    = done_q;
    if (hz.dmem_busy) begin
      state_d   = MEM_WAIT;
      mdu_cnt_d = cnt_dec;
      if (cnt_dec_to_zero) done_d = 1'b1;
    end else if (mdu_phase) begin
      mdu_cnt_d = cnt_dec;
      if (cnt_dec_to_zero) begin
        state_d = RUN;
        done_d  = 1'b1;
      end else begin
        state_d = MDU_WAIT;
      end
    end else begin
      // RUN rules: done masks the start of the op that is just leaving EX.
      state_d = RUN;
      done_d  = 1'b0;
      if (!hz.ex_branch_tk && mdu_start_ok) begin
        mdu_cnt_d = CW'(MDU_LAT - 1);
        if (MDU_LAT == 1) done_d  = 1'b1;
        else              state_d = MDU_WAIT;
      end
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    exmem_bubble = 1'b0;
    mdu_busy     = (mdu_cnt_q != '0);
    if (hz.dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
    end else if (mdu_phase || (hz.ex_mdu_start && !done_q && !hz.ex_branch_tk)) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_hold    = 1'b1;
      exmem_bubble = 1'b1;
      mdu_busy     = 1'b1;
    end else if (hz.ex_branch_tk) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_hold    = idex_hold;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.exmem_hold   = exmem_hold;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.mdu_busy     = mdu_busy;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
  assign hz.dbg_state    = state_q;
endmodule
